// File: rtl/branch_predictor_gshare.sv
// rtl/branch_predictor_gshare.sv - gshare direction predictor with tagged BTB
// Combinational lookup; PHT, BTB and both history registers update on the clock.
module branch_predictor_gshare #(
  parameter int IDX_BITS = 8,
  parameter int GHR_BITS = 4,
  parameter int TAG_BITS = 8,
  parameter int CNT_BITS = 2
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                lookup_en,
  input  logic [31:0]         PC_Current,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic [IDX_BITS-1:0] pred_index,
  input  logic                update_valid,
  input  logic [31:0]         update_pc,
  input  logic [IDX_BITS-1:0] update_index,
  input  logic                update_taken,
  input  logic [31:0]         update_target,
  input  logic                update_mispredict,
  input  logic                bp_flush
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};

  logic [CNT_BITS-1:0] r_pht     [ENTRIES];
  logic [ENTRIES-1:0]  r_btb_valid;
  logic [TAG_BITS-1:0] r_btb_tag [ENTRIES];
  logic [29:0]         r_btb_tgt [ENTRIES];

  logic [IDX_BITS-1:0] w_pc_idx;
  logic [TAG_BITS-1:0] w_pc_tag;
  logic [IDX_BITS-1:0] w_hist;
  logic [IDX_BITS-1:0] w_idx;
  logic                w_hit;
  logic [CNT_BITS-1:0] w_pred_cnt;
  logic [CNT_BITS-1:0] w_upd_cnt;
  logic [CNT_BITS-1:0] w_upd_cnt_next;
  logic [IDX_BITS-1:0] w_upd_bidx;
  logic [TAG_BITS-1:0] w_upd_tag;
  logic                w_unused;

  assign w_pc_idx   = PC_Current[IDX_BITS+1:2];
  assign w_pc_tag   = PC_Current[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign w_idx      = w_pc_idx ^ w_hist;
  assign w_hit      = r_btb_valid[w_pc_idx] && (r_btb_tag[w_pc_idx] == w_pc_tag);
  assign w_pred_cnt = r_pht[w_idx];

  assign pred_index  = w_idx;
  assign pred_taken  = w_hit && w_pred_cnt[CNT_BITS-1];
  assign pred_target = pred_taken ? {r_btb_tgt[w_pc_idx], 2'b00} : PC_Current + 32'd4;

  assign w_upd_bidx = update_pc[IDX_BITS+1:2];
  assign w_upd_tag  = update_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign w_upd_cnt  = r_pht[update_index];

  always_comb begin
    w_upd_cnt_next = w_upd_cnt;
    if (update_taken && (w_upd_cnt != CNT_MAX))
      w_upd_cnt_next = w_upd_cnt + 1'b1;
    else if (!update_taken && (w_upd_cnt != '0))
      w_upd_cnt_next = w_upd_cnt - 1'b1;
  end

  // The counter still trains on a flush cycle; only BTB and history are cleared.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) r_pht[i] <= CNT_INIT;
    end else if (update_valid) begin
      r_pht[update_index] <= w_upd_cnt_next;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_btb_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_btb_tag[i] <= '0;
        r_btb_tgt[i] <= '0;
      end
    end else if (bp_flush) begin
      r_btb_valid <= '0;
    end else if (update_valid && update_taken) begin
      r_btb_valid[w_upd_bidx] <= 1'b1;
      r_btb_tag[w_upd_bidx]   <= w_upd_tag;
      r_btb_tgt[w_upd_bidx]   <= update_target[31:2];
    end
  end

  generate
    if (GHR_BITS > 0) begin : g_ghr
      logic [GHR_BITS-1:0] r_spec_ghr;
      logic [GHR_BITS-1:0] r_arch_ghr;
      logic [GHR_BITS:0]   w_arch_ext;
      logic [GHR_BITS:0]   w_spec_ext;

      assign w_arch_ext = {r_arch_ghr, update_taken};
      assign w_spec_ext = {r_spec_ghr, pred_taken};
      assign w_hist     = IDX_BITS'(r_spec_ghr);

      // A mispredict resynchronises speculative history to the corrected architectural one.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          r_spec_ghr <= '0;
          r_arch_ghr <= '0;
        end else if (bp_flush) begin
          r_spec_ghr <= '0;
          r_arch_ghr <= '0;
        end else begin
          if (update_valid)
            r_arch_ghr <= w_arch_ext[GHR_BITS-1:0];
          if (update_valid && update_mispredict)
            r_spec_ghr <= w_arch_ext[GHR_BITS-1:0];
          else if (lookup_en && w_hit)
            r_spec_ghr <= w_spec_ext[GHR_BITS-1:0];
        end
      end
    end else begin : g_no_ghr
      assign w_hist = '0;
    end
  endgenerate

  assign w_unused = ^{update_pc[1:0], update_pc[31:IDX_BITS+TAG_BITS+2], update_target[1:0],
                      update_mispredict, lookup_en};

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb/tb_branch_predictor_gshare.sv - random and directed check of gshare predictor
// Two instances (4-bit history and pure bimodal) share stimulus and a behavioural model.
module tb_branch_predictor_gshare;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        lookup_en;
  logic [31:0] PC_Current;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [7:0]  update_index;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_mispredict;
  logic        bp_flush;

  logic        pt0, pt1;
  logic [31:0] tg0, tg1;
  logic [7:0]  ix0, ix1;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  always #5 CLK = ~CLK;

  branch_predictor_gshare u_dut (
    .CLK(CLK), .nRST(nRST), .lookup_en(lookup_en), .PC_Current(PC_Current),
    .pred_taken(pt0), .pred_target(tg0), .pred_index(ix0),
    .update_valid(update_valid), .update_pc(update_pc), .update_index(update_index),
    .update_taken(update_taken), .update_target(update_target),
    .update_mispredict(update_mispredict), .bp_flush(bp_flush)
  );

  branch_predictor_gshare #(.GHR_BITS(0)) u_dut_b (
    .CLK(CLK), .nRST(nRST), .lookup_en(lookup_en), .PC_Current(PC_Current),
    .pred_taken(pt1), .pred_target(tg1), .pred_index(ix1),
    .update_valid(update_valid), .update_pc(update_pc), .update_index(update_index),
    .update_taken(update_taken), .update_target(update_target),
    .update_mispredict(update_mispredict), .bp_flush(bp_flush)
  );

  // Model: index 0 has 4 history bits, index 1 has none (history modulus 1 keeps it at 0).
  int          m_pht [2][256];
  bit          m_bv  [2][256];
  int          m_tag [2][256];
  logic [31:0] m_tgt [2][256];
  int          m_sg  [2];
  int          m_ag  [2];

  function automatic int hmod(int m);
    return (m == 0) ? 16 : 1;
  endfunction

  function automatic int slot(logic [31:0] pc);
    return int'((pc >> 2) & 32'hff);
  endfunction

  function automatic int tagof(logic [31:0] pc);
    return int'((pc >> 10) & 32'hff);
  endfunction

  function automatic int f_idx(int m, logic [31:0] pc);
    return slot(pc) ^ m_sg[m];
  endfunction

  function automatic bit f_hit(int m, logic [31:0] pc);
    return m_bv[m][slot(pc)] && (m_tag[m][slot(pc)] == tagof(pc));
  endfunction

  function automatic bit f_taken(int m, logic [31:0] pc);
    return f_hit(m, pc) && (m_pht[m][f_idx(m, pc)] >= 2);
  endfunction

  function automatic logic [31:0] f_tgt(int m, logic [31:0] pc);
    return f_taken(m, pc) ? m_tgt[m][slot(pc)] : pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 256; i++) begin
        m_pht[m][i] = 1;
        m_bv[m][i]  = 1'b0;
        m_tag[m][i] = 0;
        m_tgt[m][i] = 32'h0;
      end
      m_sg[m] = 0;
      m_ag[m] = 0;
    end
  endtask

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      model_reset();
    end else begin
      for (int m = 0; m < 2; m++) begin
        bit h;
        bit t;
        int na;
        h  = f_hit(m, PC_Current);
        t  = f_taken(m, PC_Current);
        na = (m_ag[m] * 2 + int'(update_taken)) % hmod(m);
        if (update_valid) begin
          if (update_taken) m_pht[m][update_index] = (m_pht[m][update_index] == 3) ? 3 : m_pht[m][update_index] + 1;
          else              m_pht[m][update_index] = (m_pht[m][update_index] == 0) ? 0 : m_pht[m][update_index] - 1;
        end
        if (bp_flush) begin
          for (int i = 0; i < 256; i++) m_bv[m][i] = 1'b0;
          m_sg[m] = 0;
          m_ag[m] = 0;
        end else begin
          if (update_valid && update_taken) begin
            m_bv[m][slot(update_pc)]  = 1'b1;
            m_tag[m][slot(update_pc)] = tagof(update_pc);
            m_tgt[m][slot(update_pc)] = update_target & 32'hffff_fffc;
          end
          if (update_valid) m_ag[m] = na;
          if (update_valid && update_mispredict) m_sg[m] = na;
          else if (lookup_en && h) m_sg[m] = (m_sg[m] * 2 + int'(t)) % hmod(m);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_on) begin
      chk("model pred_taken g4",  32'(pt0), 32'(f_taken(0, PC_Current)));
      chk("model pred_target g4", tg0,      f_tgt(0, PC_Current));
      chk("model pred_index g4",  32'(ix0), 32'(f_idx(0, PC_Current)));
      chk("model pred_taken g0",  32'(pt1), 32'(f_taken(1, PC_Current)));
      chk("model pred_target g0", tg1,      f_tgt(1, PC_Current));
      chk("model pred_index g0",  32'(ix1), 32'(f_idx(1, PC_Current)));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [7:0] idx, input logic tk,
                     input logic [31:0] tgt, input logic mis);
    update_valid = 1'b1; update_pc = pc; update_index = idx;
    update_taken = tk; update_target = tgt; update_mispredict = mis;
    step();
    update_valid = 1'b0; update_mispredict = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] rpc();
    logic [31:0] p;
    p = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    return p;
  endfunction

  initial begin
    nRST = 1'b0; lookup_en = 1'b0; PC_Current = 32'h100;
    update_valid = 1'b0; update_pc = '0; update_index = '0; update_taken = 1'b0;
    update_target = '0; update_mispredict = 1'b0; bp_flush = 1'b0;
    step();
    cmp_on = 1'b1;
    step();
    chk("reset pred_taken",  32'(pt0), 32'h0);
    chk("reset pred_target", tg0, 32'h104);
    nRST = 1'b1;
    step();

    chk("post-reset pred_taken",  32'(pt0), 32'h0);
    chk("post-reset pred_target", tg0, 32'h104);
    chk("post-reset pred_index",  32'(ix0), 32'h40);
    chk("post-reset pred_index g0", 32'(ix1), 32'h40);

    update_valid = 1'b1; update_pc = 32'h100; update_index = 8'h40;
    update_taken = 1'b1; update_target = 32'h200;
    #1;
    chk("same-cycle lookup old state", 32'(pt1), 32'h0);
    step();
    update_valid = 1'b0;
    #1;
    chk("trained pred_taken g0",  32'(pt1), 32'h1);
    chk("trained pred_target g0", tg1, 32'h200);
    chk("trained pred_taken g4",  32'(pt0), 32'h1);

    PC_Current = 32'h500;
    #1;
    chk("alias pred_taken",  32'(pt1), 32'h0);
    chk("alias pred_target", tg1, 32'h504);

    PC_Current = 32'h100;
    repeat (4) upd(32'h100, 8'h40, 1'b0, 32'h0, 1'b0);
    upd(32'h100, 8'h40, 1'b1, 32'h200, 1'b0);
    chk("weak counter pred_taken",  32'(pt1), 32'h0);
    chk("weak counter pred_target", tg1, 32'h104);

    repeat (2) upd(32'h100, 8'h40, 1'b1, 32'h200, 1'b0);
    repeat (2) upd(32'h100, 8'h41, 1'b1, 32'h200, 1'b0);
    repeat (2) upd(32'h100, 8'h43, 1'b1, 32'h200, 1'b0);
    repeat (4) upd(32'h100, 8'h90, 1'b0, 32'h0, 1'b0);
    lookup_en = 1'b1;
    #1;
    chk("hist idx 0000", 32'(ix0), 32'h40);
    chk("hist taken 1", 32'(pt0), 32'h1);
    step();
    chk("hist idx 0001", 32'(ix0), 32'h41);
    chk("hist taken 2", 32'(pt0), 32'h1);
    step();
    chk("hist idx 0011", 32'(ix0), 32'h43);
    chk("hist taken 3", 32'(pt0), 32'h1);
    step();
    chk("hist idx 0111", 32'(ix0), 32'h47);
    upd(32'h100, 8'h90, 1'b0, 32'h0, 1'b1);
    lookup_en = 1'b0;
    #1;
    chk("mispredict restores history", 32'(ix0), 32'h40);

    upd(32'h140, 8'h11, 1'b1, 32'h300, 1'b0);
    lookup_en = 1'b1; bp_flush = 1'b1;
    upd(32'h100, 8'h50, 1'b1, 32'h200, 1'b0);
    lookup_en = 1'b0; bp_flush = 1'b0;
    #1;
    chk("flush btb 0x100 taken",  32'(pt0), 32'h0);
    chk("flush btb 0x100 target", tg0, 32'h104);
    chk("flush spec ghr",         32'(ix0), 32'h40);
    PC_Current = 32'h140;
    #1;
    chk("flush btb 0x140 taken", 32'(pt0), 32'h0);
    upd(32'h140, 8'h11, 1'b1, 32'h300, 1'b0);
    chk("flush pht still trained",  32'(pt0), 32'h1);
    chk("flush pht target",         tg0, 32'h300);
    chk("flush pht still trained g0", 32'(pt1), 32'h1);
    PC_Current = 32'h100;
    upd(32'h100, 8'h90, 1'b0, 32'h0, 1'b1);
    chk("flush arch ghr", 32'(ix0), 32'h42);

    for (int c = 0; c < 3000; c++) begin
      lookup_en         = ($urandom_range(0, 3) != 0);
      PC_Current        = rpc();
      update_valid      = $urandom_range(0, 1) == 1;
      update_pc         = rpc();
      update_index      = 8'($urandom_range(0, 15));
      update_taken      = $urandom_range(0, 1) == 1;
      update_target     = $urandom;
      update_mispredict = ($urandom_range(0, 3) == 0);
      bp_flush          = ($urandom_range(0, 63) == 0);
      if (c == 1500) begin
        nRST = 1'b0;
        update_valid = 1'b1;
      end
      if (c == 1502) nRST = 1'b1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor_gshare.md
BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001 SHALL have parameter IDX_BITS, default 8, log2 of PHT/BTB entry count.
REQ-002 SHALL have parameter GHR_BITS, default 4, global history length; range 0..IDX_BITS, where 0 gives pure bimodal.
REQ-003 SHALL have parameter TAG_BITS, default 8, BTB tag width.
REQ-004 SHALL have parameter CNT_BITS, default 2, saturating counter width, minimum 2.
REQ-005 CLK  in  1  clock; one clock domain only.
REQ-006 nRST  in  1  reset, asynchronous, active-low.
REQ-007 lookup_en  in  1  fetch presents a valid PC this cycle.
REQ-008 PC_Current  in  32  fetch PC.
REQ-009 pred_taken  out  1  predict taken.
REQ-010 pred_target  out  32  next-fetch address.
REQ-011 pred_index  out  IDX_BITS  PHT index used; carried down the pipe.
REQ-012 update_valid  in  1  resolved conditional branch (BEQ/BNE) in MEM.
REQ-013 update_pc  in  32  PC of the resolved branch.
REQ-014 update_index  in  IDX_BITS  pred_index captured at fetch.
REQ-015 update_taken  in  1  actual outcome.
REQ-016 update_target  in  32  actual branch target.
REQ-017 update_mispredict  in  1  direction or target was wrong; qualified by update_valid.
REQ-018 bp_flush  in  1  invalidate BTB and clear history (context change).

Function
REQ-019 Storage SHALL be: PHT of 2^IDX_BITS CNT_BITS-bit counters; BTB of 2^IDX_BITS entries {valid, tag, target[31:2]}; spec_ghr and arch_ghr, each GHR_BITS wide.
REQ-020 pred_index SHALL equal PC_Current[IDX_BITS+1:2] XOR zero-extended spec_ghr, combinationally.
REQ-021 BTB index SHALL be PC[IDX_BITS+1:2]; tag SHALL be PC[IDX_BITS+TAG_BITS+1:IDX_BITS+2]; hit = valid AND tag equal.
REQ-022 pred_taken SHALL be hit AND PHT[pred_index] MSB; pred_target SHALL be {target,2'b00} if pred_taken, else PC_Current+4 (mod 2^32).
REQ-023 Lookup SHALL be combinational, zero latency; updates SHALL become visible to lookups the cycle after they are applied (same-cycle lookup sees old state).
REQ-024 On update_valid, PHT[update_index] SHALL increment if update_taken, else decrement, saturating at 2^CNT_BITS-1 and 0.
REQ-025 On update_valid AND update_taken, the BTB entry at update_pc's index SHALL be written with valid=1, update_pc tag, and update_target[31:2], overwriting any alias.
REQ-026 A not-taken update SHALL leave the BTB unchanged.
REQ-027 On update_valid, arch_ghr SHALL shift left, inserting update_taken at bit 0.
REQ-028 On lookup_en AND hit, spec_ghr SHALL shift left, inserting pred_taken.
REQ-029 On update_valid AND update_mispredict, spec_ghr SHALL load the new arch_ghr value ({arch_ghr,update_taken} truncated); this overrides REQ-028 in the same cycle.
REQ-030 With GHR_BITS=0, both GHRs SHALL be absent and the index SHALL be the PC bits only.
REQ-031 bp_flush SHALL clear all BTB valid bits and both GHRs at the next edge, overriding REQ-025, REQ-027, REQ-028 and REQ-029 that cycle; the PHT update of REQ-024 SHALL still apply.

Reset
REQ-032 While nRST=0, all counters SHALL be 2^(CNT_BITS-1)-1 (weakly not-taken, 01 by default), all BTB valid bits, tags and targets 0, and both GHRs 0.
REQ-033 Outputs SHALL follow reset state: pred_taken=0, pred_target=PC_Current+4.
REQ-034 Reset asserted mid-operation SHALL discard any in-flight update in the same cycle.

Verification
REQ-035 Post-reset, PC_Current=0x100 -> pred_taken=0, pred_target=0x104, pred_index=0x40.
REQ-036 GHR_BITS=0: one update for pc 0x100 (taken, target 0x200, index 0x40) -> next cycle lookup 0x100 gives pred_taken=1, pred_target=0x200.
REQ-037 GHR_BITS=0: counter at 0x40 driven by 4 not-taken updates then 1 taken update -> counter=1, pred_taken=0 despite BTB hit.
REQ-038 Aliasing: after REQ-036, lookup 0x500 (same index, different tag) -> pred_taken=0, pred_target=0x504.
REQ-039 History: 3 hit-and-taken lookups give spec_ghr=0111; then a mispredicted not-taken update with arch_ghr=0000 -> spec_ghr=0000 the next cycle, even if lookup_en and hit are also asserted that cycle.
REQ-040 bp_flush asserted in the same cycle as a taken update -> no BTB entry is valid afterwards, the counter is still incremented, and both GHRs are 0.
